jtkcpu_useq: RTL and testbench

Parametrised microcode sequencer for the KCPU family: it generates the microcode ROM address from opcode categories, microcode control bits, a subroutine return stack and a prioritised multi-channel interrupt controller. It sits between the opcode decoder and the microcode ROM. It generalises the fixed single-level sequencer to N interrupt channels with a per-channel edge/level mode and to nested microcode subroutines, with sticky error detection.

---
 rtl/jtkcpu_useq_if.sv | 33 +++
 rtl/jtkcpu_useq.sv | 132 +++++++++++++
 tb/tb_jtkcpu_useq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/jtkcpu_useq_if.sv
// Bus between the opcode decoder / microcode ROM side and the KCPU microcode sequencer.
// The master drives opcode categories, microcode control bits and interrupt lines.
interface jtkcpu_useq_if #(
  parameter int AW   = 10,
  parameter int CW   = 6,
  parameter int NINT = 4
);
  logic            cen;
  logic            stall;
  logic [CW-1:0]   cat;
  logic [CW-1:0]   tgt;
  logic            ni;
  logic            jmp;
  logic            call;
  logic            ret;
  logic [NINT-1:0] int_req;
  logic [NINT-1:0] int_mask;
  logic [AW-1:0]   uaddr;
  logic            fetch;
  logic [NINT-1:0] int_ack;
  logic            intsrv;
  logic            buserror;

  modport master (
    output cen, stall, cat, tgt, ni, jmp, call, ret, int_req, int_mask,
    input  uaddr, fetch, int_ack, intsrv, buserror
  );

  modport slave (
    input  cen, stall, cat, tgt, ni, jmp, call, ret, int_req, int_mask,
    output uaddr, fetch, int_ack, intsrv, buserror
  );
endinterface

// File: rtl/jtkcpu_useq.sv
// KCPU microcode sequencer: category entry points, nested microcode subroutines,
// prioritised edge/level interrupt channels and a sticky HALT on illegal conditions.
module jtkcpu_useq #(
  parameter int              AW      = 10,
  parameter int              CW      = 6,
  parameter int              NINT    = 4,
  parameter logic [NINT-1:0] EDGE    = 4'b0001,
  parameter int              SD      = 2,
  parameter int              INTBASE = 1,
  parameter int              RSTCAT  = 0,
  parameter logic [CW-1:0]   ERRCAT  = '1
) (
  input logic clk,
  input logic rst,
  jtkcpu_useq_if.slave bus
);

  localparam int ZW  = AW - CW;
  localparam int SPW = $clog2(SD + 1);
  localparam logic [AW-1:0] RST_ADDR = {CW'(RSTCAT), {ZW{1'b0}}};

  typedef enum logic [1:0] { RUN, FETCH, HALT } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   uaddr, uaddr_nxt;
  logic [SPW-1:0]  sp, sp_nxt, sp_m1;
  logic            push;
  logic [NINT-1:0] pend_q, req_d, ack_q, ack_nxt, clr;
  logic [NINT-1:0] pend, avail, ent_oh;
  logic [CW-1:0]   ent_cat;
  logic            found;
  logic [AW-1:0]   stack [2**SPW];

  // Edge channels come from the latched bits, level channels follow the request live
  assign pend  = (EDGE & pend_q) | (~EDGE & bus.int_req);
  assign avail = pend & ~bus.int_mask;
  assign sp_m1 = sp - 1'b1;

  always_comb begin
    found   = 1'b0;
    ent_cat = '0;
    ent_oh  = '0;
    for (int k = 0; k < NINT; k++) begin
      if (!found && avail[k]) begin
        found     = 1'b1;
        ent_cat   = CW'(INTBASE + k);
        ent_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    uaddr_nxt = uaddr;
    sp_nxt    = sp;
    push      = 1'b0;
    ack_nxt   = '0;
    clr       = '0;
    case (state)
      RUN: begin
        if (!bus.stall) begin
          if (bus.ni && found) begin
            uaddr_nxt = {ent_cat, {ZW{1'b0}}};
            ack_nxt   = ent_oh;
            clr       = ent_oh;
            sp_nxt    = '0;
          end else if (bus.ni) begin
            state_nxt = FETCH;
          end else if (bus.ret) begin
            if (sp == '0) begin
              state_nxt = HALT;
            end else begin
              uaddr_nxt = stack[sp_m1];
              sp_nxt    = sp_m1;
            end
          end else if (bus.call) begin
            if (sp == SPW'(SD)) begin
              state_nxt = HALT;
            end else begin
              push      = 1'b1;
              uaddr_nxt = {bus.tgt, {ZW{1'b0}}};
              sp_nxt    = sp + 1'b1;
            end
          end else if (bus.jmp) begin
            uaddr_nxt = {bus.tgt, {ZW{1'b0}}};
          end else begin
            uaddr_nxt = uaddr + 1'b1;
          end
        end
      end
      FETCH: begin
        if (bus.cat == ERRCAT) begin
          state_nxt = HALT;
        end else begin
          uaddr_nxt = {bus.cat, {ZW{1'b0}}};
          state_nxt = RUN;
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  // A fresh edge in the ack cycle wins over the clear so it is not lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      uaddr  <= RST_ADDR;
      sp     <= '0;
      pend_q <= '0;
      req_d  <= '0;
      ack_q  <= '0;
    end else if (bus.cen) begin
      state  <= state_nxt;
      uaddr  <= uaddr_nxt;
      sp     <= sp_nxt;
      ack_q  <= ack_nxt;
      req_d  <= bus.int_req;
      pend_q <= EDGE & ((pend_q & ~clr) | (bus.int_req & ~req_d));
    end
  end

  always_ff @(posedge clk) begin
    if (bus.cen && push) stack[sp] <= uaddr + 1'b1;
  end

  assign bus.uaddr    = uaddr;
  assign bus.fetch    = (state == FETCH);
  assign bus.buserror = (state == HALT);
  assign bus.int_ack  = ack_q;
  assign bus.intsrv   = |avail;

endmodule

// File: tb/tb_jtkcpu_useq.sv
// Directed bench for jtkcpu_useq: a vector table for the main flow plus
// hand-written sequences for stack overflow/underflow, wrap, HALT and reset.
module tb_jtkcpu_useq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failures = 0;

  jtkcpu_useq_if #(.AW(10), .CW(6), .NINT(4)) bus ();

  jtkcpu_useq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cen, stall, ni, jmp, call, ret;
    logic [5:0] tgt, cat;
    logic [3:0] req, mask;
    logic [9:0] uaddr;
    logic       fetch;
    logic [3:0] ack;
    logic       intsrv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit cen, bit stall, bit ni, bit jmp, bit call, bit ret,
                              logic [5:0] tgt, logic [5:0] cat, logic [3:0] req,
                              logic [3:0] mask, logic [9:0] ua, bit f, logic [3:0] ack,
                              bit is);
    vec_t v;
    v.cen = cen; v.stall = stall; v.ni = ni; v.jmp = jmp; v.call = call; v.ret = ret;
    v.tgt = tgt; v.cat = cat; v.req = req; v.mask = mask;
    v.uaddr = ua; v.fetch = f; v.ack = ack; v.intsrv = is;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cen = 1'b1; bus.stall = 1'b0; bus.ni = 1'b0; bus.jmp = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.tgt = '0; bus.cat = '0;
    bus.int_req = '0; bus.int_mask = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.cen = v.cen; bus.stall = v.stall; bus.ni = v.ni; bus.jmp = v.jmp;
    bus.call = v.call; bus.ret = v.ret; bus.tgt = v.tgt; bus.cat = v.cat;
    bus.int_req = v.req; bus.int_mask = v.mask;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input logic [9:0] ua, input bit f, input bit err);
    checkOutput({name, " uaddr"}, 32'(bus.uaddr), 32'(ua));
    checkOutput({name, " fetch"}, 32'(bus.fetch), 32'(f));
    checkOutput({name, " buserror"}, 32'(bus.buserror), 32'(err));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle();
    // Table: cen stall ni jmp call ret tgt cat req mask -> uaddr fetch ack intsrv
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h001,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h002,0,4'h0,0));
    tbl.push_back(mk(1,0,0,1,0,0,6'h04,6'h00,4'h0,4'h0,10'h040,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h041,0,4'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h041,0,4'h0,0));
    tbl.push_back(mk(0,0,0,1,0,0,6'h09,6'h00,4'h0,4'h0,10'h041,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h042,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h043,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h044,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h045,0,4'h0,0));
    tbl.push_back(mk(1,0,1,0,0,0,6'h00,6'h12,4'h0,4'h0,10'h045,1,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h12,4'h0,4'h0,10'h120,0,4'h0,0));
    tbl.push_back(mk(1,0,0,1,0,0,6'h08,6'h00,4'h0,4'h0,10'h080,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,1,0,6'h03,6'h00,4'h0,4'h0,10'h030,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h031,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,1,6'h00,6'h00,4'h0,4'h0,10'h081,0,4'h0,0));
    tbl.push_back(mk(1,1,1,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h081,0,4'h0,0));
    tbl.push_back(mk(1,1,1,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h081,0,4'h0,0));
    tbl.push_back(mk(1,1,1,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h081,0,4'h0,0));
    tbl.push_back(mk(1,0,1,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h081,1,4'h0,0));
    tbl.push_back(mk(1,1,0,0,0,0,6'h00,6'h05,4'h0,4'h0,10'h050,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h1,4'h1,10'h051,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h1,10'h052,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h053,0,4'h0,1));
    tbl.push_back(mk(1,0,1,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h010,0,4'h1,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h011,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h4,4'h0,10'h012,0,4'h0,1));
    tbl.push_back(mk(1,0,1,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h012,1,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h07,4'h0,4'h0,10'h070,0,4'h0,0));
    tbl.push_back(mk(1,0,1,0,0,0,6'h00,6'h00,4'ha,4'h0,10'h020,0,4'h2,1));
    tbl.push_back(mk(1,0,1,0,0,0,6'h00,6'h00,4'h8,4'h0,10'h040,0,4'h8,1));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h041,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h1,4'h0,10'h042,0,4'h0,1));
    tbl.push_back(mk(1,0,1,0,0,0,6'h00,6'h00,4'h1,4'h0,10'h010,0,4'h1,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h1,4'h0,10'h011,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h012,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,1,0,6'h03,6'h00,4'h0,4'h0,10'h030,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,1,0,6'h05,6'h00,4'h0,4'h0,10'h050,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,1,6'h00,6'h00,4'h0,4'h0,10'h031,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,1,6'h00,6'h00,4'h0,4'h0,10'h013,0,4'h0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h1,4'h0,10'h014,0,4'h0,1));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h015,0,4'h0,1));
    tbl.push_back(mk(1,0,1,0,0,0,6'h00,6'h00,4'h1,4'h0,10'h010,0,4'h1,1));
    tbl.push_back(mk(1,0,1,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h010,0,4'h1,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,6'h00,4'h0,4'h0,10'h011,0,4'h0,0));

    // Reset state
    #12;
    checkState("reset", 10'h000, 0, 0);
    checkOutput("reset int_ack", 32'(bus.int_ack), 32'h0);
    checkOutput("reset intsrv", 32'(bus.intsrv), 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkState($sformatf("row%0d", i), tbl[i].uaddr, tbl[i].fetch, 0);
      checkOutput($sformatf("row%0d int_ack", i), 32'(bus.int_ack), 32'(tbl[i].ack));
      checkOutput($sformatf("row%0d intsrv", i), 32'(bus.intsrv), 32'(tbl[i].intsrv));
    end

    // Three nested calls with depth 2: HALT with uaddr frozen
    idle();
    bus.call = 1'b1; bus.tgt = 6'h01; tick();
    checkState("ovf call1", 10'h010, 0, 0);
    bus.tgt = 6'h02; tick();
    checkState("ovf call2", 10'h020, 0, 0);
    bus.tgt = 6'h03; tick();
    checkState("ovf call3", 10'h020, 0, 1);
    bus.call = 1'b0; bus.jmp = 1'b1; bus.tgt = 6'h09; tick();
    checkState("ovf frozen", 10'h020, 0, 1);
    bus.jmp = 1'b0; bus.int_req = 4'h4; #1;
    checkOutput("halt intsrv", 32'(bus.intsrv), 32'h1);
    rst = 1'b1; #1;
    checkState("ovf async reset", 10'h000, 0, 0);
    #2 rst = 1'b0;
    idle();

    // Interrupt entry empties the stack, so a following ret underflows
    bus.call = 1'b1; bus.tgt = 6'h03; tick();
    checkState("unf call", 10'h030, 0, 0);
    bus.call = 1'b0; bus.int_req = 4'h2; bus.ni = 1'b1; tick();
    checkState("unf int entry", 10'h020, 0, 0);
    checkOutput("unf int_ack", 32'(bus.int_ack), 32'h2);
    bus.int_req = 4'h0; bus.ni = 1'b0; bus.ret = 1'b1; tick();
    checkState("unf ret", 10'h020, 0, 1);
    idle();
    rst = 1'b1; #2 rst = 1'b0;

    // Address wrap from 0x3FF to 0x000
    bus.jmp = 1'b1; bus.tgt = 6'h3f; tick();
    checkState("wrap jmp", 10'h3f0, 0, 0);
    bus.jmp = 1'b0;
    repeat (15) tick();
    checkState("wrap top", 10'h3ff, 0, 0);
    tick();
    checkState("wrap zero", 10'h000, 0, 0);

    // Illegal category in FETCH, then reset with an edge request held high
    bus.ni = 1'b1; tick();
    checkState("err fetch", 10'h000, 1, 0);
    bus.ni = 1'b0; bus.cat = 6'h3f; tick();
    checkState("err halt", 10'h000, 0, 1);
    tick();
    checkState("err sticky", 10'h000, 0, 1);
    bus.cat = 6'h00; bus.int_req = 4'h1; #1;
    rst = 1'b1; #1;
    checkState("err async reset", 10'h000, 0, 0);
    tick();
    #2 rst = 1'b0; #1;
    checkOutput("edge through reset not latched", 32'(bus.intsrv), 32'h0);
    tick();
    checkOutput("edge after release", 32'(bus.intsrv), 32'h1);
    checkState("edge after release", 10'h001, 0, 0);
    bus.ni = 1'b1; tick();
    checkState("edge entry", 10'h010, 0, 0);
    checkOutput("edge entry int_ack", 32'(bus.int_ack), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
